adc128s022_responder: RTL and testbench



---
 rtl/adc128_pkg.sv | 25 ++
 rtl/sync_edge.sv | 42 ++++
 rtl/adc128s022_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_adc128s022_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc128_pkg.sv
// adc128_pkg
//   Shared types and constants for the ADC128S022 responder.
//   Frame layout: FRAME_BITS serial bits, LEAD_ZEROS zero bits followed by
//   the 12-bit sample, MSB first. The 3-bit channel address arrives on DIN
//   at rising sclk edges ADDR_FIRST_EDGE .. ADDR_FIRST_EDGE+2.
package adc128_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int LEAD_ZEROS      = 4;

  typedef logic [2:0]  ch_t;
  typedef logic [11:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Serial word for a sample: leading zeros, then the sample MSB first.
  function automatic logic [FRAME_BITS-1:0] make_word(input sample_t s);
    return {{LEAD_ZEROS{1'b0}}, s};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Multi-flop synchronizer for one asynchronous input, with single-cycle
//   rise/fall pulses derived from the synchronized value.
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   asynchronous active-low reset
//   d_i      in   asynchronous input
//   level_o  out  synchronized level (STAGES flops after d_i)
//   rise_o   out  one-cycle pulse when level_o goes 0 -> 1
//   fall_o   out  one-cycle pulse when level_o goes 1 -> 0
// The pulses are combinational from level_o and its registered copy, so an
// action registered on a pulse lands STAGES+1 cycles after the pin edge.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// adc128s022_responder
//   Device side of the ADC128S022 serial interface, emulated in the
//   clock_50 domain. Samples come from a parallel per-channel bus.
// Ports:
//   clock_50       in   system clock
//   reset_n        in   asynchronous active-low reset
//   spi_cs_n       in   chip select (async)
//   spi_sclk       in   serial clock, idles high (async)
//   spi_saddr      in   DIN, channel address (async)
//   spi_sdat_o     out  DOUT value
//   spi_sdat_oe    out  DOUT enable, pad tristated when 0
//   ch_data        in   samples, channel k at [k*DATA_W +: DATA_W]
//   frame_done     out  one-cycle pulse at the 16th rising sclk edge
//   frame_ch       out  channel shifted out in that frame, valid with frame_done
//   frame_abort    out  one-cycle pulse when cs_n rises mid-frame
//   dbg_state_o    out  FSM state
//   dbg_next_ch_o  out  channel the next cs_n-started frame will return
// Interface behaviour: there is no valid/ready handshake. The initiator owns
// all timing: cs_n low frames the transfer, DOUT changes after each falling
// sclk edge and is sampled by the initiator on the rising edge, DIN is taken
// on rising edges. frame_done and frame_abort are unqualified single-cycle
// strobes with no backpressure.
module adc128s022_responder
  import adc128_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock_50,
  input  logic                     reset_n,
  input  logic                     spi_cs_n,
  input  logic                     spi_sclk,
  input  logic                     spi_saddr,
  output logic                     spi_sdat_o,
  output logic                     spi_sdat_oe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_done,
  output ch_t                      frame_ch,
  output logic                     frame_abort,
  output state_e                   dbg_state_o,
  output ch_t                      dbg_next_ch_o
);

  localparam logic [3:0] LAST_EDGE = 4'(FRAME_BITS - 1);
  // Rising-count values (before increment) at which ADD2/ADD1/ADD0 arrive.
  localparam logic [3:0] ADD2_CNT  = 4'(ADDR_FIRST_EDGE - 1);
  localparam logic [3:0] ADD1_CNT  = 4'(ADDR_FIRST_EDGE);
  localparam logic [3:0] ADD0_CNT  = 4'(ADDR_FIRST_EDGE + 1);

  // ---------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic saddr_level, saddr_rise, saddr_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk_i   (clock_50),
    .rst_ni  (reset_n),
    .d_i     (spi_sclk),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i   (clock_50),
    .rst_ni  (reset_n),
    .d_i     (spi_cs_n),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
    .clk_i   (clock_50),
    .rst_ni  (reset_n),
    .d_i     (spi_saddr),
    .level_o (saddr_level),
    .rise_o  (saddr_rise),
    .fall_o  (saddr_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{sclk_level, saddr_rise, saddr_fall};

  // ---------------------------------------------------------------------
  // Sample selection
  // ---------------------------------------------------------------------
  sample_t samples [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_samples
    assign samples[k] = ch_data[k*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------
  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [3:0]              rise_cnt_q;
  logic [3:0]              fall_cnt_q;
  ch_t                     addr_q;      // address being assembled from DIN
  ch_t                     next_ch_q;   // channel for the next cs_n-started frame
  ch_t                     cur_ch_q;    // channel currently on the shifter
  ch_t                     rise_ch_q;   // channel of the frame the rising count belongs to
  logic                    sdat_q;
  logic                    sdat_oe_q;
  logic                    done_q;
  logic                    abort_q;
  ch_t                     frame_ch_q;
  logic [SYNC_STAGES-1:0]  settle_q;
  logic                    cs_armed_q;

  logic [FRAME_BITS-1:0]   start_word;
  logic [FRAME_BITS-1:0]   cont_word;

  assign start_word = make_word(samples[next_ch_q]);
  // In continuous mode the 16th falling edge precedes the 16th rising edge,
  // so the reload takes the fully assembled address (complete since rising
  // edge 5) rather than waiting for next_ch_q to update.
  assign cont_word  = make_word(samples[addr_q]);

  // The cs_n synchronizer resets to "high". If the pin is already low when
  // reset releases, the chain flushing to 0 would look like a fall and start
  // a frame mid-transfer. cs_armed_q only opens once the flushed chain shows
  // cs_n high, so a reset inside a frame waits for a genuine fall.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      addr_q     <= '0;
      next_ch_q  <= '0;
      cur_ch_q   <= '0;
      rise_ch_q  <= '0;
      sdat_q     <= 1'b0;
      sdat_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      frame_ch_q <= '0;
      settle_q   <= '0;
      cs_armed_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settle_q[SYNC_STAGES-1] && cs_level) begin
        cs_armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          sdat_oe_q <= 1'b0;
          sdat_q    <= 1'b0;
          if (cs_fall && cs_armed_q) begin
            state_q    <= SHIFT;
            sdat_oe_q  <= 1'b1;
            shreg_q    <= start_word;
            sdat_q     <= start_word[FRAME_BITS-1];
            cur_ch_q   <= next_ch_q;
            rise_ch_q  <= next_ch_q;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // cs_n rise has priority over any sclk edge in the same cycle.
            state_q   <= IDLE;
            sdat_oe_q <= 1'b0;
            sdat_q    <= 1'b0;
            if (rise_cnt_q != 4'd0) begin
              abort_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              if (rise_cnt_q == ADD2_CNT) addr_q[2] <= saddr_level;
              if (rise_cnt_q == ADD1_CNT) addr_q[1] <= saddr_level;
              if (rise_cnt_q == ADD0_CNT) addr_q[0] <= saddr_level;
              if (rise_cnt_q == LAST_EDGE) begin
                // Count reaches 16: frame complete, count wraps to 0.
                rise_cnt_q <= '0;
                done_q     <= 1'b1;
                frame_ch_q <= rise_ch_q;
                next_ch_q  <= addr_q;
                rise_ch_q  <= addr_q;
              end else begin
                rise_cnt_q <= rise_cnt_q + 4'd1;
              end
            end
            if (sclk_fall) begin
              if (fall_cnt_q == LAST_EDGE) begin
                // 16th falling edge: start the following word.
                shreg_q    <= cont_word;
                sdat_q     <= cont_word[FRAME_BITS-1];
                cur_ch_q   <= addr_q;
                fall_cnt_q <= '0;
              end else begin
                shreg_q    <= {shreg_q[FRAME_BITS-2:0], 1'b0};
                sdat_q     <= shreg_q[FRAME_BITS-2];
                fall_cnt_q <= fall_cnt_q + 4'd1;
              end
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          sdat_oe_q <= 1'b0;
          sdat_q    <= 1'b0;
        end
      endcase
    end
  end

  assign spi_sdat_o    = sdat_q;
  assign spi_sdat_oe   = sdat_oe_q;
  assign frame_done    = done_q;
  assign frame_ch      = frame_ch_q;
  assign frame_abort   = abort_q;
  assign dbg_state_o   = state_q;
  assign dbg_next_ch_o = next_ch_q;

endmodule

// File: tb/tb_adc128s022_responder.sv
`timescale 1ns/1ps
module tb_adc128s022_responder;
  import adc128_pkg::*;

  // -----------------------------------------------------------------------
  // Clock / reset
  // -----------------------------------------------------------------------
  logic        clock_50;
  logic        reset_n;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_saddr;
  logic        spi_sdat_o;
  logic        spi_sdat_oe;
  logic [95:0] ch_data;
  logic        frame_done;
  ch_t         frame_ch;
  logic        frame_abort;
  state_e      dbg_state;
  ch_t         dbg_next_ch;

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  adc128s022_responder dut (
    .clock_50      (clock_50),
    .reset_n       (reset_n),
    .spi_cs_n      (spi_cs_n),
    .spi_sclk      (spi_sclk),
    .spi_saddr     (spi_saddr),
    .spi_sdat_o    (spi_sdat_o),
    .spi_sdat_oe   (spi_sdat_oe),
    .ch_data       (ch_data),
    .frame_done    (frame_done),
    .frame_ch      (frame_ch),
    .frame_abort   (frame_abort),
    .dbg_state_o   (dbg_state),
    .dbg_next_ch_o (dbg_next_ch)
  );

  // -----------------------------------------------------------------------
  // Scoreboard state
  // -----------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [2:0]  done_ch_q[$];
  logic [11:0] mdl_data [8];
  int          abort_cycles = 0;
  int          checks = 0;
  int          errors = 0;

  // One entry per cycle that frame_done is high, so a stretched pulse shows
  // up as an extra entry.
  always @(negedge clock_50) begin
    if (frame_done) done_ch_q.push_back(frame_ch);
    if (frame_abort) abort_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] word, input logic [2:0] exp_ch);
    logic [15:0] exp_w;
    exp_w = exp_q.pop_front();
    check({tag, " word"}, 32'(word), 32'(exp_w));
    check({tag, " done seen"}, 32'(done_ch_q.size() > 0), 32'd1);
    if (done_ch_q.size() > 0) check({tag, " frame_ch"}, 32'(done_ch_q.pop_front()), 32'(exp_ch));
  endtask

  // -----------------------------------------------------------------------
  // Driver tasks
  // -----------------------------------------------------------------------
  task automatic set_ch(input int k, input logic [11:0] v);
    mdl_data[k] = v;
    ch_data[k*12 +: 12] = v;
  endtask

  // n sclk periods inside a frame. Bit 15 is taken just before the first
  // falling edge, bit 15-p at the end of the p-th low phase.
  task automatic run_bits(input int phase, input logic [2:0] addr, input int n,
                          output logic [15:0] word);
    word = '0;
    for (int p = 1; p <= n; p++) begin
      if (p == 1) word[15] = spi_sdat_o;
      spi_sclk = 1'b0;
      if (p == 3)      spi_saddr = addr[2];
      else if (p == 4) spi_saddr = addr[1];
      else if (p == 5) spi_saddr = addr[0];
      else             spi_saddr = 1'($urandom_range(0, 1));
      #(phase);
      if (p <= 15) word[15-p] = spi_sdat_o;
      spi_sclk = 1'b1;
      #(phase);
    end
  endtask

  task automatic do_frame(input int phase, input logic [2:0] addr, output logic [15:0] word);
    spi_cs_n = 1'b0;
    #(phase);
    run_bits(phase, addr, 16, word);
    spi_cs_n = 1'b1;
    #(phase);
  endtask

  // -----------------------------------------------------------------------
  // Directed sequence
  // -----------------------------------------------------------------------
  initial begin
    logic [15:0] w, w2;
    logic [2:0]  a;
    logic [2:0]  mdl_next;

    reset_n   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b1;
    spi_saddr = 1'b0;
    ch_data   = '0;
    for (int k = 0; k < 8; k++) mdl_data[k] = '0;

    #53;
    check("rst sdat", 32'(spi_sdat_o), 32'd0);
    check("rst oe", 32'(spi_sdat_oe), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst abort", 32'(frame_abort), 32'd0);
    check("rst frame_ch", 32'(frame_ch), 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    check("rst next_ch", 32'(dbg_next_ch), 32'd0);

    // All SPI activity from here sits 3 ns after a rising clock edge.
    @(posedge clock_50);
    #3;
    reset_n = 1'b1;
    #200;

    // Single frame, 1 MHz, ch0 changed after load must not matter.
    set_ch(0, 12'hABC);
    exp_q.push_back(16'h0ABC);
    spi_cs_n = 1'b0;
    #500;
    check("t1 oe", 32'(spi_sdat_oe), 32'd1);
    check("t1 state", 32'(dbg_state), 32'(SHIFT));
    set_ch(0, 12'h321);
    run_bits(500, 3'd5, 16, w);
    spi_cs_n = 1'b1;
    #500;
    check_frame("t1", w, 3'd0);
    check("t1 next_ch", 32'(dbg_next_ch), 32'd5);
    check("t1 oe off", 32'(spi_sdat_oe), 32'd0);
    check("t1 state idle", 32'(dbg_state), 32'(IDLE));

    // Back-to-back frames.
    set_ch(5, 12'h123);
    set_ch(2, 12'hFFF);
    exp_q.push_back(16'h0123);
    do_frame(500, 3'd2, w);
    check_frame("t2a", w, 3'd5);
    exp_q.push_back(16'h0FFF);
    do_frame(500, 3'd0, w);
    check_frame("t2b", w, 3'd2);
    check("t2 extra done", 32'(done_ch_q.size()), 32'd0);

    // Continuous mode: 32 periods with cs_n held low.
    set_ch(3, 12'h555);
    exp_q.push_back(16'h0321);
    exp_q.push_back(16'h0555);
    spi_cs_n = 1'b0;
    #500;
    run_bits(500, 3'd3, 16, w);
    run_bits(500, 3'd4, 16, w2);
    spi_cs_n = 1'b1;
    #500;
    check_frame("t3a", w, 3'd0);
    check_frame("t3b", w2, 3'd3);
    check("t3 extra done", 32'(done_ch_q.size()), 32'd0);
    check("t3 next_ch", 32'(dbg_next_ch), 32'd4);
    check("t3 abort", 32'(abort_cycles), 32'd0);

    // Abort after 7 rising edges carrying address 6.
    set_ch(4, 12'h4A4);
    set_ch(6, 12'h666);
    spi_cs_n = 1'b0;
    #500;
    run_bits(500, 3'd6, 7, w);
    spi_cs_n = 1'b1;
    #60;
    check("t4 oe off", 32'(spi_sdat_oe), 32'd0);
    #440;
    check("t4 abort", 32'(abort_cycles), 32'd1);
    check("t4 no done", 32'(done_ch_q.size()), 32'd0);
    check("t4 next_ch", 32'(dbg_next_ch), 32'd4);
    exp_q.push_back(16'h04A4);
    do_frame(500, 3'd1, w);
    check_frame("t4", w, 3'd4);
    check("t4 next_ch after", 32'(dbg_next_ch), 32'd1);

    // Reset at rising edge 10.
    spi_cs_n = 1'b0;
    #500;
    run_bits(500, 3'd7, 9, w);
    spi_sclk = 1'b0;
    #500;
    spi_sclk = 1'b1;
    reset_n  = 1'b0;
    #1;
    check("t5 oe in reset", 32'(spi_sdat_oe), 32'd0);
    check("t5 sdat in reset", 32'(spi_sdat_o), 32'd0);
    #499;
    reset_n = 1'b1;
    run_bits(500, 3'd3, 6, w);
    check("t5 oe after", 32'(spi_sdat_oe), 32'd0);
    check("t5 state", 32'(dbg_state), 32'(IDLE));
    check("t5 no done", 32'(done_ch_q.size()), 32'd0);
    check("t5 abort", 32'(abort_cycles), 32'd1);
    spi_cs_n = 1'b1;
    #500;
    // sclk toggling with cs_n high is ignored.
    run_bits(80, 3'd2, 20, w);
    check("t5 idle oe", 32'(spi_sdat_oe), 32'd0);
    check("t5 idle done", 32'(done_ch_q.size()), 32'd0);
    check("t5 idle next_ch", 32'(dbg_next_ch), 32'd0);
    exp_q.push_back(16'h0321);
    do_frame(500, 3'd2, w);
    check_frame("t5", w, 3'd0);

    // Edge-rate limit: 80 ns phases, random addresses and data.
    mdl_next = 3'd2;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) set_ch(k, 12'($urandom_range(0, 4095)));
      a = 3'($urandom_range(0, 7));
      exp_q.push_back({4'h0, mdl_data[mdl_next]});
      do_frame(80, a, w);
      check_frame($sformatf("rnd%0d", i), w, mdl_next);
      mdl_next = a;
    end
    check("rnd aborts", 32'(abort_cycles), 32'd1);
    check("rnd extra done", 32'(done_ch_q.size()), 32'd0);
    check("rnd next_ch", 32'(dbg_next_ch), 32'(mdl_next));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
